// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the decode hazard controller and its scoreboard.
package hazard_ctrl_pkg;

    localparam int                   REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] ZERO_REG  = 5'd0;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        FLUSH = 2'b01
    } state_e;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_scoreboard.sv
// Pending-writeback scoreboard: one busy bit per register, bit 0 hardwired clear.
// Lookups see same-cycle writebacks as already retired (register file bypass).
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_addr,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_addr,
    input  logic [REG_IDX_W-1:0] rs1_addr,
    input  logic [REG_IDX_W-1:0] rs2_addr,
    input  logic [REG_IDX_W-1:0] rd_addr,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 rd_busy,
    output logic [NUM_REGS-1:0]  busy_vec
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] set_vec, clr_vec, eff_busy;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en) set_vec[set_addr] = 1'b1;
        if (clr_en) clr_vec[clr_addr] = 1'b1;

        eff_busy = busy_q & ~clr_vec;

        // Set is applied after clear so a new writer keeps the register busy.
        busy_d    = eff_busy | set_vec;
        busy_d[0] = 1'b0;
    end

    assign rs1_busy = eff_busy[rs1_addr];
    assign rs2_busy = eff_busy[rs2_addr];
    assign rd_busy  = eff_busy[rd_addr];
    assign busy_vec = busy_q;

    // NOTE: the scoreboard is a flop vector, not a RAM, so it resets to empty in one step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

endmodule : hazard_scoreboard

// File: rtl/decode_hazard_ctrl.sv
// Decode issue controller: RAW/WAW stall, EX-redirect flush window, ID->EX issue gating.
// Optional perf counters are enabled with the HAZARD_PERF_CNT_EN macro.
module decode_hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int FLUSH_CYCLES = 1
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W        = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_wb_reg_file,
    input  logic                 ex_ready,
    input  logic                 ex_redirect,
    input  logic                 reg_file_wr_en,
    input  logic [REG_IDX_W-1:0] reg_file_wr_addr,
    output logic                 issue,
    output logic                 id_stall,
    output logic                 id_flush,
    output logic [NUM_REGS-1:0]  busy_vec
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
`endif
);

    localparam logic [2:0] FCNT_RELOAD = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

    state_e     state_q, state_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic       rs1_busy, rs2_busy, rd_busy;
    logic       hazard, flush_raw, set_en;

    hazard_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_addr (id_rd),
        .clr_en   (reg_file_wr_en),
        .clr_addr (reg_file_wr_addr),
        .rs1_addr (id_rs1),
        .rs2_addr (id_rs2),
        .rd_addr  (id_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy),
        .busy_vec (busy_vec)
    );

    assign hazard = id_valid & ((id_use_rs1 & rs1_busy) | (id_use_rs2 & rs2_busy)
                              | (id_wb_reg_file & rd_busy));
    assign flush_raw = ex_redirect | (state_q == FLUSH);

    // Reset masks the combinational outputs so nothing issues or flushes while held.
    assign issue    = rst & id_valid & ~hazard & ex_ready & ~flush_raw;
    assign id_stall = rst & id_valid & ~flush_raw & (hazard | ~ex_ready);
    assign id_flush = rst & flush_raw;
    assign set_en   = issue & id_wb_reg_file & (id_rd != ZERO_REG);

    // NOTE: next-state logic assigns defaults first so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            RUN: begin
                if (ex_redirect && (FLUSH_CYCLES > 1)) begin
                    state_d = FLUSH;
                    fcnt_d  = FCNT_RELOAD;
                end
            end
            FLUSH: begin
                if (ex_redirect)          fcnt_d  = FCNT_RELOAD;
                else if (fcnt_q == 3'd0)  state_d = RUN;
                else                      fcnt_d  = fcnt_q - 3'd1;
            end
            default: begin
                state_d = RUN;
                fcnt_d  = 3'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            fcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    // Both counters saturate at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (id_stall && (stall_cnt_q != '1))    stall_cnt_d = stall_cnt_q + 1'b1;
        if (ex_redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule : decode_hazard_ctrl

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl against a register-array reference model.
module tb_decode_hazard_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0, reg_file_wr_addr = '0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_wb_reg_file = 1'b0;
    logic        ex_ready = 1'b1, ex_redirect = 1'b0, reg_file_wr_en = 1'b0;
    logic        issue, id_stall, id_flush;
    logic [31:0] busy_vec;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    int               stall_m = 0, flush_m = 0;
`endif

    always #5 clk = ~clk;

    decode_hazard_ctrl #(
        .NUM_REGS     (32),
        .FLUSH_CYCLES (FLUSH_CYCLES)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .CNT_W        (CNT_W)
`endif
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_use_rs1       (id_use_rs1),
        .id_use_rs2       (id_use_rs2),
        .id_rd            (id_rd),
        .id_wb_reg_file   (id_wb_reg_file),
        .ex_ready         (ex_ready),
        .ex_redirect      (ex_redirect),
        .reg_file_wr_en   (reg_file_wr_en),
        .reg_file_wr_addr (reg_file_wr_addr),
        .issue            (issue),
        .id_stall         (id_stall),
        .id_flush         (id_flush),
        .busy_vec         (busy_vec)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
`endif
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: which registers have an outstanding writer, and how many
    // further cycles the current redirect keeps ID flushed.
    bit          busy_m[32];
    int          flush_left = 0;
    logic        exp_issue, exp_stall, exp_flush;
    logic [31:0] exp_vec;

    task automatic model_clear();
        for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
        flush_left = 0;
`ifdef HAZARD_PERF_CNT_EN
        stall_m = 0;
        flush_m = 0;
`endif
    endtask

    task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit wb, input bit rdy, input bit redir,
                         input bit wr, input int wa);
        id_valid         = v;
        id_rs1           = 5'(rs1);
        id_use_rs1       = u1;
        id_rs2           = 5'(rs2);
        id_use_rs2       = u2;
        id_rd            = 5'(rd);
        id_wb_reg_file   = wb;
        ex_ready         = rdy;
        ex_redirect      = redir;
        reg_file_wr_en   = wr;
        reg_file_wr_addr = 5'(wa);
    endtask

    // Expected outputs for the inputs currently applied, from the model state.
    task automatic predict();
        bit pending[32];
        bit haz;
        for (int i = 0; i < 32; i++)
            pending[i] = busy_m[i] && !(reg_file_wr_en && int'(reg_file_wr_addr) == i);
        haz = id_valid && ((id_use_rs1 && id_rs1 != 0 && pending[id_rs1])
                        || (id_use_rs2 && id_rs2 != 0 && pending[id_rs2])
                        || (id_wb_reg_file && id_rd != 0 && pending[id_rd]));
        exp_flush = ex_redirect || (flush_left > 0);
        exp_issue = id_valid && !haz && ex_ready && !exp_flush;
        exp_stall = id_valid && !exp_flush && (haz || !ex_ready);
        for (int i = 0; i < 32; i++) exp_vec[i] = busy_m[i];
    endtask

    // Advance the model by one clock and move to 1 time unit after the edge.
    task automatic commit();
        if (reg_file_wr_en) busy_m[reg_file_wr_addr] = 1'b0;
        if (exp_issue && id_wb_reg_file && id_rd != 0) busy_m[id_rd] = 1'b1;
        if (ex_redirect)         flush_left = FLUSH_CYCLES - 1;
        else if (flush_left > 0) flush_left = flush_left - 1;
`ifdef HAZARD_PERF_CNT_EN
        if (exp_stall && stall_m < (1 << CNT_W) - 1)   stall_m++;
        if (ex_redirect && flush_m < (1 << CNT_W) - 1) flush_m++;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 3, 1, 4, 1, 6, 1, 1, 0, 0, 0);
        for (int c = 0; c < 2; c++) begin
            #1;
            tests_run++;
            if (busy_vec !== 32'd0 || issue !== 1'b0 || id_stall !== 1'b0 || id_flush !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs: got vec=%h issue=%b stall=%b flush=%b want 0/0/0/0",
                         busy_vec, issue, id_stall, id_flush);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        model_clear();
    endtask

    task automatic test_raw();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        #1; predict();
        tests_run++;
        if (issue !== exp_issue || exp_issue !== 1'b1) begin
            tests_failed++;
            $display("FAIL raw_producer_issue: got %b want %b", issue, exp_issue);
        end
        commit();
        drive(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        #1; predict();
        tests_run++;
        if (id_stall !== exp_stall || issue !== exp_issue || busy_vec !== exp_vec) begin
            tests_failed++;
            $display("FAIL raw_stall: got stall=%b issue=%b vec=%h want %b %b %h",
                     id_stall, issue, busy_vec, exp_stall, exp_issue, exp_vec);
        end
        commit();
        drive(1, 5, 1, 0, 0, 0, 0, 1, 0, 1, 5);
        #1; predict();
        tests_run++;
        if (issue !== exp_issue || id_stall !== exp_stall) begin
            tests_failed++;
            $display("FAIL raw_bypass_issue: got issue=%b stall=%b want %b %b",
                     issue, id_stall, exp_issue, exp_stall);
        end
        commit();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        #1; predict();
        tests_run++;
        if (busy_vec !== exp_vec) begin
            tests_failed++;
            $display("FAIL raw_cleared: got %h want %h", busy_vec, exp_vec);
        end
    endtask

    task automatic test_x0();
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        #1; predict();
        commit();
        drive(1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0);
        #1; predict();
        tests_run++;
        if (busy_vec !== exp_vec || issue !== exp_issue || id_stall !== exp_stall) begin
            tests_failed++;
            $display("FAIL x0_no_track: got vec=%h issue=%b stall=%b want %h %b %b",
                     busy_vec, issue, id_stall, exp_vec, exp_issue, exp_stall);
        end
        commit();
    endtask

    task automatic test_redirect();
        drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
        #1; predict();
        commit();
        for (int c = 0; c < 4; c++) begin
            drive(1, 2, 1, 3, 1, 4, 1, 1, (c == 0), 0, 0);
            #1; predict();
            tests_run++;
            if (id_flush !== exp_flush || issue !== exp_issue || id_stall !== exp_stall
                || busy_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL redirect_c%0d: got flush=%b issue=%b stall=%b vec=%h want %b %b %b %h",
                         c, id_flush, issue, id_stall, busy_vec, exp_flush, exp_issue, exp_stall, exp_vec);
            end
            commit();
        end
    endtask

    task automatic test_race();
        drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0);
        #1; predict();
        commit();
        drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 1, 9);
        #1; predict();
        tests_run++;
        if (issue !== exp_issue) begin
            tests_failed++;
            $display("FAIL race_issue: got %b want %b", issue, exp_issue);
        end
        commit();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        #1; predict();
        tests_run++;
        if (busy_vec !== exp_vec || busy_vec[9] !== 1'b1) begin
            tests_failed++;
            $display("FAIL race_set_wins: got %h want %h", busy_vec, exp_vec);
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 4; c++) begin
            drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            #1; predict();
            tests_run++;
            if (id_stall !== exp_stall || issue !== exp_issue || busy_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL backpressure_c%0d: got stall=%b issue=%b vec=%h want %b %b %h",
                         c, id_stall, issue, busy_vec, exp_stall, exp_issue, exp_vec);
            end
`ifdef HAZARD_PERF_CNT_EN
            tests_run++;
            if (int'(stall_cnt) != stall_m || int'(flush_cnt) != flush_m) begin
                tests_failed++;
                $display("FAIL perf_cnt_c%0d: got stall=%0d flush=%0d want %0d %0d",
                         c, stall_cnt, flush_cnt, stall_m, flush_m);
            end
`endif
            commit();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 1) != 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7));
            #1; predict();
            tests_run++;
            if (issue !== exp_issue || id_stall !== exp_stall || id_flush !== exp_flush
                || busy_vec !== exp_vec) begin
                tests_failed++;
                $display("FAIL random_c%0d: got issue=%b stall=%b flush=%b vec=%h want %b %b %b %h",
                         c, issue, id_stall, id_flush, busy_vec, exp_issue, exp_stall, exp_flush, exp_vec);
            end
`ifdef HAZARD_PERF_CNT_EN
            tests_run++;
            if (int'(stall_cnt) != stall_m || int'(flush_cnt) != flush_m) begin
                tests_failed++;
                $display("FAIL random_perf_c%0d: got stall=%0d flush=%0d want %0d %0d",
                         c, stall_cnt, flush_cnt, stall_m, flush_m);
            end
`endif
            commit();
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0);
        #1; predict();
        commit();
        drive(1, 12, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        #1; predict();
        commit();
        drive(1, 12, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        #1; predict();
        tests_run++;
        if (id_flush !== exp_flush || exp_flush !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_pre_flush: got %b want %b", id_flush, exp_flush);
        end
        #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (busy_vec !== 32'd0 || id_flush !== 1'b0 || issue !== 1'b0 || id_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_async_reset: got vec=%h flush=%b issue=%b stall=%b want 0/0/0/0",
                     busy_vec, id_flush, issue, id_stall);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
        drive(1, 12, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        #1; predict();
        tests_run++;
        if (id_flush !== exp_flush || issue !== exp_issue || busy_vec !== exp_vec) begin
            tests_failed++;
            $display("FAIL mid_post_reset: got flush=%b issue=%b vec=%h want %b %b %h",
                     id_flush, issue, busy_vec, exp_flush, exp_issue, exp_vec);
        end
        commit();
    endtask

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_raw();
        test_x0();
        test_redirect();
        test_race();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_decode_hazard_ctrl
